// File: rtl/galois_pkg.sv
// Shared field-arithmetic definitions for the BN254 pow-7 datapath and its arbiter.
package galois_pkg;
  localparam int unsigned N_BITS       = 254;
  localparam int unsigned MULT_LATENCY = 13;
  localparam int unsigned POW7_LATENCY = 3 * MULT_LATENCY;

  typedef logic [N_BITS-1:0] felem_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } pow_tag_t;
endpackage

// File: rtl/galois_pow7_tag_pipe.sv
// Tag shift register that follows each operand through the pow-7 core;
// valids clear on rst so in-core results are dropped.
module galois_pow7_tag_pipe
  import galois_pkg::*;
#(
  parameter int unsigned DEPTH = POW7_LATENCY + 1
) (
  input  logic     clk,
  input  logic     rst,
  input  pow_tag_t tag_in,
  output pow_tag_t tag_out
);

  pow_tag_t pipe_q [DEPTH];
  pow_tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i].valid <= 1'b0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/galois_pow_7_arbiter.sv
// Round-robin sharing of one pipelined x^7 mod p core among N_REQ requesters.
// Optional GALOIS_POW7_ARB_OCCUPANCY_EN adds an in_flight occupancy counter.
module galois_pow_7_arbiter
  import galois_pkg::*;
#(
  parameter int unsigned N_BITS      = galois_pkg::N_BITS,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned POW_LATENCY = galois_pkg::POW7_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*N_BITS-1:0] req_base,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_BITS-1:0]       pow_base,
  input  logic [N_BITS-1:0]       pow_result,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_BITS-1:0]       rsp_result
`ifdef GALOIS_POW7_ARB_OCCUPANCY_EN
  ,
  output logic [$clog2(POW_LATENCY+2)-1:0] in_flight
`endif
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic              transfer;
  logic [N_BITS-1:0] pow_base_q, pow_base_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [N_BITS-1:0] rsp_result_q, rsp_result_d;
  pow_tag_t          tag_in, tag_out;

  // Search starts at the pointer and wraps, so the nearest requester wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign transfer  = found && !rst;
  assign req_ready = N_REQ'(transfer) << grant_idx;

  always_comb begin
    ptr_d        = ptr_q;
    pow_base_d   = '0;
    tag_in.valid = transfer;
    tag_in.id    = 3'(grant_idx);
    if (transfer) begin
      ptr_d      = ID_W'((32'(grant_idx) + 1) % N_REQ);
      pow_base_d = req_base[32'(grant_idx) * N_BITS +: N_BITS];
    end
    rsp_valid_d  = N_REQ'(tag_out.valid) << tag_out.id;
    rsp_result_d = pow_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      pow_base_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pow_base_q   <= pow_base_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  galois_pow7_tag_pipe #(
    .DEPTH(POW_LATENCY + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign pow_base   = pow_base_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;

`ifdef GALOIS_POW7_ARB_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(POW_LATENCY + 2);

  logic [OCC_W-1:0] in_flight_q, in_flight_d;

  always_comb begin
    in_flight_d = in_flight_q;
    unique case ({transfer, tag_out.valid})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (32'(in_flight_q) <= POW_LATENCY + 1);
  end

  assign in_flight = in_flight_q;
`endif

endmodule
